// File: rtl/load_search_scheduler.sv
// load_search_scheduler
//   Picks the oldest eligible load each cycle and presents it to the
//   load/store dependence checker. On the following cycle the verdict is
//   applied: issue to L1, forward from a store, or sleep until the store
//   queue changes.
//   Optional build macro: LOAD_SEARCH_PERF_EN adds saturating 32-bit
//   verdict counters (perf_fwd_count, perf_sleep_count, perf_mem_count).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_READY  | free to be searched once the load has a valid address
//   ST_SEARCH | presented to the checker this cycle, verdict pending
//   ST_SLEEP  | blocked by an older store without data, waits for stq_wake
//   ST_DONE   | issued to L1 or forwarded; idle until deallocated
module load_search_scheduler #(
   parameter int LDQ_SIZE = 8,
   parameter int STQ_SIZE = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [LDQ_SIZE-1:0]         ldq_valid,
   input  logic [LDQ_SIZE-1:0]         ldq_address_valid,
   input  logic [$clog2(LDQ_SIZE)-1:0] ldq_head,
   input  logic                        stq_wake,
   output logic                        search_valid,
   output logic [$clog2(LDQ_SIZE)-1:0] search_index,
   input  logic                        chk_kill_mem_req,
   input  logic                        chk_forward,
   input  logic [$clog2(STQ_SIZE)-1:0] chk_stq_index,
   output logic                        mem_req_valid,
   output logic [$clog2(LDQ_SIZE)-1:0] mem_req_index,
   input  logic                        mem_req_ready,
   output logic                        fwd_valid,
   output logic [$clog2(LDQ_SIZE)-1:0] fwd_ldq_index,
   output logic [$clog2(STQ_SIZE)-1:0] fwd_stq_index
`ifdef LOAD_SEARCH_PERF_EN
   ,
   output logic [31:0]                 perf_fwd_count,
   output logic [31:0]                 perf_sleep_count,
   output logic [31:0]                 perf_mem_count
`endif
);

   localparam int LW = $clog2(LDQ_SIZE);

   typedef enum logic [1:0] {
      ST_READY  = 2'd0,
      ST_SEARCH = 2'd1,
      ST_SLEEP  = 2'd2,
      ST_DONE   = 2'd3
   } ld_state_t;

   ld_state_t         ld_state [LDQ_SIZE];
   logic [LDQ_SIZE-1:0] eligible;
   logic              pick_found;
   logic [LW-1:0]     pick_index;
   logic [LW-1:0]     cand;
   logic              verdict_live;
   logic              v_mem;
   logic              v_fwd;
   logic              v_sleep;
   logic              mem_busy;
   logic              v_mem_issue;
   logic              v_mem_retry;
   logic              start;

   // Eligible loads and the oldest one relative to the queue head.
   always_comb begin
      eligible   = '0;
      pick_found = 1'b0;
      pick_index = '0;
      cand       = '0;
      for (int i = 0; i < LDQ_SIZE; i++) begin
         eligible[i] = ldq_valid[i] & ldq_address_valid[i] & (ld_state[i] == ST_READY);
      end
      // Walk from youngest age to oldest so the smallest age wins.
      for (int a = LDQ_SIZE - 1; a >= 0; a--) begin
         cand = ldq_head + LW'(a);
         if (eligible[cand]) begin
            pick_found = 1'b1;
            pick_index = cand;
         end
      end
   end

   // Verdict decode for the load under search; a deallocated load's verdict is dropped.
   always_comb begin
      verdict_live = search_valid & ldq_valid[search_index];
      v_mem        = verdict_live & ~chk_kill_mem_req;
      v_fwd        = verdict_live & chk_kill_mem_req & chk_forward;
      v_sleep      = verdict_live & chk_kill_mem_req & ~chk_forward;
      // The request register stays occupied next cycle only if a live request is refused.
      mem_busy     = mem_req_valid & ldq_valid[mem_req_index] & ~mem_req_ready;
      // An issue verdict that finds the request port still held goes back to READY and retries.
      v_mem_issue  = v_mem & ~mem_busy;
      v_mem_retry  = v_mem & mem_busy;
      start        = pick_found & ~mem_busy;
   end

   // Search launch, verdict application and per-load state tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         search_valid  <= 1'b0;
         search_index  <= '0;
         mem_req_valid <= 1'b0;
         mem_req_index <= '0;
         fwd_valid     <= 1'b0;
         fwd_ldq_index <= '0;
         fwd_stq_index <= '0;
         for (int i = 0; i < LDQ_SIZE; i++) ld_state[i] <= ST_READY;
      end else begin
         search_valid <= start;
         if (start) search_index <= pick_index;

         fwd_valid <= v_fwd;
         if (v_fwd) begin
            fwd_ldq_index <= search_index;
            fwd_stq_index <= chk_stq_index;
         end

         if (v_mem_issue) begin
            mem_req_valid <= 1'b1;
            mem_req_index <= search_index;
         end else if (!mem_busy) begin
            mem_req_valid <= 1'b0;
         end

         // Later assignments take priority: wake, verdict, new search, dealloc.
         for (int i = 0; i < LDQ_SIZE; i++) begin
            if (stq_wake && ld_state[i] == ST_SLEEP) ld_state[i] <= ST_READY;
            if (verdict_live && search_index == LW'(i)) begin
               if (v_sleep)          ld_state[i] <= stq_wake ? ST_READY : ST_SLEEP;
               else if (v_mem_retry) ld_state[i] <= ST_READY;
               else                  ld_state[i] <= ST_DONE;
            end
            if (start && pick_index == LW'(i)) ld_state[i] <= ST_SEARCH;
            if (!ldq_valid[i]) ld_state[i] <= ST_READY;
         end
      end
   end

`ifdef LOAD_SEARCH_PERF_EN
   // Saturating verdict counters; only verdicts that take effect are counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fwd_count   <= '0;
         perf_sleep_count <= '0;
         perf_mem_count   <= '0;
      end else begin
         if (v_fwd && perf_fwd_count != 32'hFFFF_FFFF)
            perf_fwd_count <= perf_fwd_count + 32'd1;
         if (v_sleep && perf_sleep_count != 32'hFFFF_FFFF)
            perf_sleep_count <= perf_sleep_count + 32'd1;
         if (v_mem_issue && perf_mem_count != 32'hFFFF_FFFF)
            perf_mem_count <= perf_mem_count + 32'd1;
      end
   end
`endif

endmodule
